muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_sign.sv | 12 +
 rtl/muldiv_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MD_ITER = 32;
  localparam int unsigned CNT_W   = $clog2(MD_ITER);

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX
  } md_state_e;

endpackage

// File: rtl/muldiv_sign.sv
// Conditional two's-complement negate; yields |x| when neg is the sign bit.
module muldiv_sign #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result_c
);

  assign result_c = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Fixed-latency radix-2 RV32M multiply/divide: IDLE -> PREP -> CALC x32 -> FIX.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] R
);

  md_state_e        state, state_n;
  logic [CNT_W-1:0] cnt;
  md_op_e           op_q;
  logic [XLEN-1:0]  a_q, b_q;
  logic [XLEN:0]    acc;
  logic [XLEN-1:0]  lo, dvs;
  logic             neg_q;

  logic            is_mul, mul_hi, a_signed, b_signed, sign_a, sign_b, neg_res;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] fix_in, fix_out;

  assign is_mul   = ~op_q[2];
  assign mul_hi   = (op_q[1:0] != 2'b00);
  assign a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
  assign b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
  assign sign_a   = a_signed & a_q[XLEN-1];
  assign sign_b   = b_signed & b_q[XLEN-1];

  // Divide by zero must not flip the all-ones quotient; remainder follows the dividend.
  always_comb begin
    neg_res = 1'b0;
    if (is_mul)        neg_res = sign_a ^ sign_b;
    else if (op_q[1])  neg_res = sign_a;
    else               neg_res = (sign_a ^ sign_b) & (b_q != '0);
  end

  muldiv_sign #(.W(XLEN)) u_abs_a (.value(a_q), .neg(sign_a), .result_c(mag_a));
  muldiv_sign #(.W(XLEN)) u_abs_b (.value(b_q), .neg(sign_b), .result_c(mag_b));

  // Result correction: division results are zero-extended so the low half negates correctly.
  assign fix_in = is_mul ? {acc[XLEN-1:0], lo}
                         : {{XLEN{1'b0}}, (op_q[1] ? acc[XLEN-1:0] : lo)};
  muldiv_sign #(.W(2*XLEN)) u_fix (.value(fix_in), .neg(neg_q), .result_c(fix_out));

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum  = acc + (lo[0] ? {1'b0, dvs} : '0);
    div_sh   = {acc[XLEN-1:0], lo[XLEN-1]};
    div_diff = div_sh - {1'b0, dvs};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_PREP;
      S_PREP: state_n = S_CALC;
      S_CALC: if (cnt == CNT_W'(MD_ITER - 1)) state_n = S_FIX;
      S_FIX:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (kill) state_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      R     <= '0;
      cnt   <= '0;
      op_q  <= OP_MUL;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      lo    <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
    end else begin
      busy <= (state_n != S_IDLE);
      done <= (state == S_FIX) && !kill;
      case (state)
        S_IDLE: begin
          if (start && !kill) begin
            op_q <= md_op_e'(op);
            a_q  <= A;
            b_q  <= B;
          end
        end
        S_PREP: begin
          cnt   <= '0;
          acc   <= '0;
          neg_q <= neg_res;
          lo    <= is_mul ? mag_b : mag_a;
          dvs   <= is_mul ? mag_a : mag_b;
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (is_mul) begin
            acc <= {1'b0, mul_sum[XLEN:1]};
            lo  <= {mul_sum[0], lo[XLEN-1:1]};
          end else begin
            acc <= div_diff[XLEN] ? div_sh : div_diff;
            lo  <= {lo[XLEN-2:0], ~div_diff[XLEN]};
          end
        end
        S_FIX: begin
          if (!kill) R <= (is_mul && mul_hi) ? fix_out[2*XLEN-1:XLEN] : fix_out[XLEN-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
